// File: rtl/cpu_machine_controller.sv
// Instruction-sequencing FSM for the 8-bit teaching CPU.
// Each instruction runs a fixed 8-state sequence: two fetch cycles, an idle
// cycle, decode, then three opcode-dependent execute cycles and a tail cycle.
module cpu_machine_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt
);

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, HALTED
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_opc;
  logic       w_alu;
  logic       w_sto;
  logic       w_jmp;
  logic       w_skz;

  // Execute-phase decode works only from the latched opcode.
  assign w_alu = (r_opc == OP_ADD) || (r_opc == OP_AND) ||
                 (r_opc == OP_XOR) || (r_opc == OP_LDA);
  assign w_sto = (r_opc == OP_STO);
  assign w_jmp = (r_opc == OP_JMP);
  assign w_skz = (r_opc == OP_SKZ);

  // State register and opcode latch; opcode captured leaving FETCH_LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S0;
      r_opc   <= OP_HLT;
    end else begin
      r_state <= w_next;
      if (r_state == S1 && ena) r_opc <= opcode;
    end
  end

  // Next state: HALTED is sticky; a low enable aborts back to FETCH_HI.
  always_comb begin
    w_next = S0;
    if (r_state == HALTED) begin
      w_next = HALTED;
    end else if (ena) begin
      case (r_state)
        S0:      w_next = S1;
        S1:      w_next = S2;
        S2:      w_next = S3;
        S3:      w_next = (r_opc == OP_HLT) ? HALTED : S4;
        S4:      w_next = S5;
        S5:      w_next = S6;
        S6:      w_next = S7;
        default: w_next = S0;
      endcase
    end
  end

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    load_ir     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (rst) begin
      case (r_state)
        S0, S1: begin
          load_ir = 1'b1;
          rd      = 1'b1;
          inc_pc  = 1'b1;
        end
        S4: begin
          rd          = w_alu;
          datactl_ena = w_sto;
          load_pc     = w_jmp;
          inc_pc      = w_skz & zero;
        end
        S5: begin
          rd          = w_alu;
          load_acc    = w_alu;
          wr          = w_sto;
          datactl_ena = w_sto;
          load_pc     = w_jmp;
        end
        S6: begin
          rd          = w_alu;
          datactl_ena = w_sto;
          inc_pc      = w_skz & zero;
        end
        HALTED:  halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_machine_controller.sv
// Scoreboard bench for cpu_machine_controller: stimulus pushes the expected
// strobe vector for each cycle, a negedge monitor pops and compares.
module tb_cpu_machine_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] expq[$];
  string      nameq[$];

  cpu_machine_controller dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_acc(load_acc), .datactl_ena(datactl_ena),
    .halt(halt)
  );

  always #5 clk = ~clk;

  // {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}
  function automatic logic [7:0] outs();
    return {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};
  endfunction

  localparam logic [7:0] V_FETCH = 8'b1101_0000;
  localparam logic [7:0] V_NONE  = 8'b0000_0000;
  localparam logic [7:0] V_HALT  = 8'b0000_0001;

  // Hand-tabled expected strobes for cycle c of an instruction.
  function automatic logic [7:0] expv(input logic [2:0] op, input int c, input logic z);
    logic alu;
    alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    if (c < 2) return V_FETCH;
    if (c < 4 || c == 7) return V_NONE;
    if (op == 3'b000) return V_HALT;
    case (c)
      4: if (alu) return 8'b0100_0000;
         else if (op == 3'b110) return 8'b0000_0010;
         else if (op == 3'b111) return 8'b0000_1000;
         else return z ? 8'b0001_0000 : V_NONE;
      5: if (alu) return 8'b0100_0100;
         else if (op == 3'b110) return 8'b0010_0010;
         else if (op == 3'b111) return 8'b0000_1000;
         else return V_NONE;
      default: if (alu) return 8'b0100_0000;
         else if (op == 3'b110) return 8'b0000_0010;
         else if (op == 3'b001) return z ? 8'b0001_0000 : V_NONE;
         else return V_NONE;
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: one output vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) check(nameq.pop_front(), outs(), expq.pop_front());
  end

  // Push cycle expectation, then step to 1ns past the next rising edge.
  task automatic step(input string nm, input logic [7:0] e);
    expq.push_back(e);
    nameq.push_back(nm);
    @(posedge clk); #1;
  endtask

  // Run cycles [0..last] of an instruction; opcode switches to op2 after capture.
  task automatic run(input string nm, input logic [2:0] op, input logic [2:0] op2,
                     input logic z, input int last);
    ena = 1'b1; opcode = op; zero = z;
    for (int c = 0; c <= last; c++) begin
      if (c == 2) opcode = op2;
      step($sformatf("%s_c%0d", nm, c), expv(op, c, z));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; ena = 1'b0; opcode = 3'b010; zero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), V_NONE);
    check("reset_opc", {5'd0, dut.r_opc}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run("add", 3'b010, 3'b010, 1'b0, 7);
    run("sto", 3'b110, 3'b110, 1'b0, 7);
    run("skz_z1", 3'b001, 3'b001, 1'b1, 7);
    run("skz_z0", 3'b001, 3'b001, 1'b0, 7);
    run("jmp_opc_swap", 3'b111, 3'b000, 1'b0, 7);
    run("xor", 3'b100, 3'b100, 1'b1, 7);

    // Enable drop in S5 aborts; next cycle is a fresh fetch.
    run("add_abort", 3'b010, 3'b010, 1'b0, 4);
    ena = 1'b0;
    step("add_abort_c5", expv(3'b010, 5, 1'b0));
    run("after_abort", 3'b011, 3'b011, 1'b0, 7);

    // HLT with enable low in decode: enable wins, no halt.
    run("hlt_ena0", 3'b000, 3'b000, 1'b0, 2);
    ena = 1'b0;
    step("hlt_ena0_c3", V_NONE);
    run("after_hlt_ena0", 3'b111, 3'b111, 1'b0, 7);

    // Real HLT: sticky for 20 cycles while enable toggles.
    run("hlt", 3'b000, 3'b000, 1'b0, 3);
    for (int i = 0; i < 20; i++) begin
      ena = i[0];
      step($sformatf("halted_%0d", i), V_HALT);
    end
    rst = 1'b0; #1;
    check("halt_rst_async", outs(), V_NONE);
    @(posedge clk); #1;
    ena = 1'b1; rst = 1'b1;
    run("post_halt_lda", 3'b101, 3'b101, 1'b0, 7);

    // Async reset mid-S5 of LDA.
    run("lda", 3'b101, 3'b101, 1'b0, 4);
    #1;
    check("lda_s5", outs(), 8'b0100_0100);
    rst = 1'b0; #1;
    check("lda_rst_async", outs(), V_NONE);
    check("lda_rst_opc", {5'd0, dut.r_opc}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run("post_rst_sto", 3'b110, 3'b110, 1'b0, 7);

    @(negedge clk);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d left, required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
